// File: rtl/tang9k_top.sv
// tang9k_top -- Tang Nano 9K top level.
// An SPI mode-0 slave bridges a host MCU to a small 32-bit register bank that
// drives the LEDs and four motor PWM outputs and reports the receiver PWM pins.
//
// Ports:
//   i_clk, i_rst            system clock (72 MHz), synchronous active-high reset
//   i_spi_clk/cs_n/mosi     SPI slave inputs (asynchronous to i_clk)
//   o_spi_miso              SPI data out, MSB first
//   o_led_1..4              LEDs, active-low
//   i_usb_uart_rx           unused; o_usb_uart_tx held idle (1)
//   i_pwm_ch0..5            receiver PWM inputs, readable via PWMIN
//   o_motor1..4             motor PWM outputs
//   o_neopixel              held 0
//   o_debug_0/1/2           synced cs_n / synced sclk / write-commit strobe
//
// Transaction: cmd byte (A2 write / A1 read), 4 address bytes MSB first, then
// either 4 write-data bytes LSB first, or 40 response bits
// {A3, D[7:0], D[15:8], D[23:16], D[31:24]}.
module tang9k_top #(
    parameter int unsigned CLK_HZ = 72_000_000,
    parameter logic [31:0] ID_VAL = 32'h5439_4B31
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_spi_clk,
    input  logic i_spi_cs_n,
    input  logic i_spi_mosi,
    output logic o_spi_miso,
    output logic o_led_1,
    output logic o_led_2,
    output logic o_led_3,
    output logic o_led_4,
    input  logic i_usb_uart_rx,
    output logic o_usb_uart_tx,
    input  logic i_pwm_ch0,
    input  logic i_pwm_ch1,
    input  logic i_pwm_ch2,
    input  logic i_pwm_ch3,
    input  logic i_pwm_ch4,
    input  logic i_pwm_ch5,
    output logic o_motor1,
    output logic o_motor2,
    output logic o_motor3,
    output logic o_motor4,
    output logic o_neopixel,
    output logic o_debug_0,
    output logic o_debug_1,
    output logic o_debug_2
);

    localparam logic [7:0] CMD_WRITE = 8'hA2;
    localparam logic [7:0] CMD_READ  = 8'hA1;
    localparam logic [7:0] RESP_HDR  = 8'hA3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_RESP,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ---------------- synchronizers and edge detect ----------------
    logic [1:0] r_sclk_sync;
    logic [1:0] r_cs_sync;
    logic [1:0] r_mosi_sync;
    logic [5:0] r_pwm_meta;
    logic [5:0] r_pwm_sync;
    logic       r_sclk_d;
    logic       r_cs_d;

    logic w_sclk;
    logic w_cs_n;
    logic w_mosi;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_fall;

    // Sync chains reset to 0 so a cs_n already held low through reset does
    // not produce a false falling edge and start a mid-frame transaction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_pwm_meta  <= '0;
            r_pwm_sync  <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], i_spi_clk};
            r_cs_sync   <= {r_cs_sync[0], i_spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[0], i_spi_mosi};
            r_pwm_meta  <= {i_pwm_ch5, i_pwm_ch4, i_pwm_ch3,
                            i_pwm_ch2, i_pwm_ch1, i_pwm_ch0};
            r_pwm_sync  <= r_pwm_meta;
            r_sclk_d    <= r_sclk_sync[1];
            r_cs_d      <= r_cs_sync[1];
        end
    end

    assign w_sclk      = r_sclk_sync[1];
    assign w_cs_n      = r_cs_sync[1];
    assign w_mosi      = r_mosi_sync[1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_cs_fall   = ~w_cs_n & r_cs_d;

    // ---------------- byte receiver ----------------
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_shift;
    logic [7:0] w_rx_byte;
    logic       w_byte_done;

    assign w_rx_byte   = {r_rx_shift[6:0], w_mosi};
    assign w_byte_done = w_sclk_rise & ~w_cs_n & (r_bit_cnt == 3'd7);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
        end else if (w_cs_n) begin
            r_bit_cnt  <= '0;
        end else if (w_sclk_rise) begin
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            r_rx_shift <= w_rx_byte;
        end
    end

    // ---------------- register bank ----------------
    logic [3:0]  r_led;
    logic [7:0]  r_motor1;
    logic [7:0]  r_motor2;
    logic [7:0]  r_motor3;
    logic [7:0]  r_motor4;
    logic [7:0]  r_pwm_cnt;

    logic [1:0]  r_byte_cnt;
    logic        r_cmd_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [39:0] r_tx;
    logic [5:0]  r_tx_cnt;
    logic        r_armed;
    logic        r_wr_strobe;

    logic [31:0] w_rd_addr;
    logic [31:0] w_rd_data;
    logic [31:0] w_wr_data;

    // Read address includes the byte completing right now, so the response
    // can be loaded in the same cycle the last address byte lands.
    assign w_rd_addr = {r_addr[23:0], w_rx_byte};
    assign w_wr_data = {w_rx_byte, r_wdata[31:8]};

    always_comb begin
        w_rd_data = '0;
        case (w_rd_addr)
            32'h0000_0000: w_rd_data = {28'd0, r_led};
            32'h0000_0004: w_rd_data = {26'd0, r_pwm_sync};
            32'h0000_0008: w_rd_data = {24'd0, r_motor1};
            32'h0000_000C: w_rd_data = {24'd0, r_motor2};
            32'h0000_0010: w_rd_data = {24'd0, r_motor3};
            32'h0000_0014: w_rd_data = {24'd0, r_motor4};
            32'h0000_0018: w_rd_data = ID_VAL;
            default:       w_rd_data = '0;
        endcase
    end

    // ---------------- transaction FSM ----------------
    logic w_cmd_en;
    logic w_addr_en;
    logic w_wdata_en;
    logic w_commit;
    logic w_load_tx;
    logic w_shift_tx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cmd_en     = 1'b0;
        w_addr_en    = 1'b0;
        w_wdata_en   = 1'b0;
        w_commit     = 1'b0;
        w_load_tx    = 1'b0;
        w_shift_tx   = 1'b0;
        if (w_cs_n) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) w_state_next = S_CMD;
                end
                S_CMD: begin
                    if (w_byte_done) begin
                        w_cmd_en = 1'b1;
                        if (w_rx_byte == CMD_WRITE || w_rx_byte == CMD_READ)
                            w_state_next = S_ADDR;
                        else
                            w_state_next = S_DONE;
                    end
                end
                S_ADDR: begin
                    if (w_byte_done) begin
                        w_addr_en = 1'b1;
                        if (r_byte_cnt == 2'd3) begin
                            if (r_cmd_wr) begin
                                w_state_next = S_WDATA;
                            end else begin
                                w_load_tx    = 1'b1;
                                w_state_next = S_RESP;
                            end
                        end
                    end
                end
                S_WDATA: begin
                    if (w_byte_done) begin
                        w_wdata_en = 1'b1;
                        if (r_byte_cnt == 2'd3) begin
                            w_commit     = 1'b1;
                            w_state_next = S_DONE;
                        end
                    end
                end
                S_RESP: begin
                    // Only falls that follow a rise seen in RESP shift; the
                    // fall closing the last address byte must not consume
                    // bit 39 before the host samples it.
                    if (w_sclk_fall && r_armed) begin
                        w_shift_tx = 1'b1;
                        if (r_tx_cnt == 6'd40) w_state_next = S_DONE;
                    end
                end
                S_DONE: ;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_byte_cnt  <= '0;
            r_cmd_wr    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_tx        <= '0;
            r_tx_cnt    <= '0;
            r_armed     <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_led       <= '0;
            r_motor1    <= '0;
            r_motor2    <= '0;
            r_motor3    <= '0;
            r_motor4    <= '0;
            r_pwm_cnt   <= '0;
        end else begin
            r_pwm_cnt   <= r_pwm_cnt + 8'd1;
            r_wr_strobe <= w_commit;

            // 2-bit counter wraps 3 -> 0 on the ADDR -> WDATA hand-off.
            if (w_cs_n)
                r_byte_cnt <= '0;
            else if (w_addr_en || w_wdata_en)
                r_byte_cnt <= r_byte_cnt + 2'd1;

            if (w_cmd_en)   r_cmd_wr <= (w_rx_byte == CMD_WRITE);
            if (w_addr_en)  r_addr   <= w_rd_addr;
            if (w_wdata_en) r_wdata  <= w_wr_data;

            if (w_load_tx) begin
                r_tx     <= {RESP_HDR, w_rd_data[7:0], w_rd_data[15:8],
                             w_rd_data[23:16], w_rd_data[31:24]};
                r_tx_cnt <= '0;
                r_armed  <= 1'b0;
            end else if (r_state == S_RESP && !w_cs_n) begin
                if (w_sclk_rise) begin
                    r_tx_cnt <= r_tx_cnt + 6'd1;
                    r_armed  <= 1'b1;
                end else if (w_shift_tx) begin
                    r_tx    <= {r_tx[38:0], 1'b0};
                    r_armed <= 1'b0;
                end
            end

            if (w_commit) begin
                case (r_addr)
                    32'h0000_0000: r_led    <= w_wr_data[3:0];
                    32'h0000_0008: r_motor1 <= w_wr_data[7:0];
                    32'h0000_000C: r_motor2 <= w_wr_data[7:0];
                    32'h0000_0010: r_motor3 <= w_wr_data[7:0];
                    32'h0000_0014: r_motor4 <= w_wr_data[7:0];
                    default: ;
                endcase
            end
        end
    end

    // ---------------- outputs ----------------
    logic w_unused;
    assign w_unused = i_usb_uart_rx | (CLK_HZ == 0);

    assign o_spi_miso    = (r_state == S_RESP) & ~w_cs_n & r_tx[39];
    assign o_led_1       = ~r_led[0];
    assign o_led_2       = ~r_led[1];
    assign o_led_3       = ~r_led[2];
    assign o_led_4       = ~r_led[3];
    assign o_motor1      = (r_pwm_cnt < r_motor1);
    assign o_motor2      = (r_pwm_cnt < r_motor2);
    assign o_motor3      = (r_pwm_cnt < r_motor3);
    assign o_motor4      = (r_pwm_cnt < r_motor4);
    assign o_usb_uart_tx = 1'b1;
    assign o_neopixel    = 1'b0;
    assign o_debug_0     = w_cs_n;
    assign o_debug_1     = w_sclk;
    assign o_debug_2     = r_wr_strobe;

endmodule

// File: tb/tb_tang9k_top.sv
module tb_tang9k_top;

    localparam int HALF = 8;  // SCLK half-period in i_clk cycles

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_clk = 1'b0;
    logic spi_cs_n = 1'b1;
    logic spi_mosi = 1'b0;
    logic uart_rx = 1'b1;
    logic [5:0] pwm_in = 6'd0;

    logic miso, led1, led2, led3, led4, uart_tx;
    logic m1, m2, m3, m4, neo, dbg0, dbg1, dbg2;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;

    always #7 clk = ~clk;

    tang9k_top dut (
        .i_clk(clk), .i_rst(rst),
        .i_spi_clk(spi_clk), .i_spi_cs_n(spi_cs_n), .i_spi_mosi(spi_mosi),
        .o_spi_miso(miso),
        .o_led_1(led1), .o_led_2(led2), .o_led_3(led3), .o_led_4(led4),
        .i_usb_uart_rx(uart_rx), .o_usb_uart_tx(uart_tx),
        .i_pwm_ch0(pwm_in[0]), .i_pwm_ch1(pwm_in[1]), .i_pwm_ch2(pwm_in[2]),
        .i_pwm_ch3(pwm_in[3]), .i_pwm_ch4(pwm_in[4]), .i_pwm_ch5(pwm_in[5]),
        .o_motor1(m1), .o_motor2(m2), .o_motor3(m3), .o_motor4(m4),
        .o_neopixel(neo),
        .o_debug_0(dbg0), .o_debug_1(dbg1), .o_debug_2(dbg2)
    );

    always @(negedge clk) if (dbg2) strobe_cnt++;

    // ---------------- SPI master helpers ----------------
    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx = {rx[6:0], miso};
            spi_clk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_clk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] addr,
                            output logic miso_seen);
        logic [7:0] rx;
        miso_seen = 1'b0;
        spi_byte(cmd, rx);           miso_seen = miso_seen | (|rx);
        spi_byte(addr[31:24], rx);   miso_seen = miso_seen | (|rx);
        spi_byte(addr[23:16], rx);   miso_seen = miso_seen | (|rx);
        spi_byte(addr[15:8], rx);    miso_seen = miso_seen | (|rx);
        spi_byte(addr[7:0], rx);     miso_seen = miso_seen | (|rx);
    endtask

    task automatic spi_write(input logic [31:0] addr, input logic [31:0] data);
        logic [7:0] rx;
        logic seen;
        cs_begin();
        send_hdr(8'hA2, addr, seen);
        for (int b = 0; b < 4; b++) spi_byte(data[8*b +: 8], rx);
        cs_end();
    endtask

    task automatic spi_read(input logic [31:0] addr, output logic [39:0] resp,
                            output logic miso_seen);
        logic [7:0] rx;
        cs_begin();
        send_hdr(8'hA1, addr, miso_seen);
        resp = '0;
        for (int b = 0; b < 5; b++) begin
            spi_byte(8'h00, rx);
            resp = {resp[31:0], rx};
        end
        cs_end();
    endtask

    task automatic check_read(input string name, input logic [31:0] addr,
                              input logic [39:0] exp);
        logic [39:0] resp;
        logic seen;
        spi_read(addr, resp, seen);
        checks++;
        if (resp !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, resp, exp);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL %s_hdr_miso: got %b expected 0", name, seen);
        end
    endtask

    function automatic int count_high_256_dummy(input int x);
        return x;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if ({miso, led4, led3, led2, led1, m1, m2, m3, m4, dbg2, uart_tx, neo}
            !== 12'b0_1111_0000_0_1_0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 011110000010",
                     {miso, led4, led3, led2, led1, m1, m2, m3, m4, dbg2, uart_tx, neo});
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (dbg0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_cs_sync: got %b expected 1", dbg0);
        end
    endtask

    task automatic test_led_write();
        logic [7:0] rx;
        logic seen;
        int s0;
        s0 = strobe_cnt;
        cs_begin();
        send_hdr(8'hA2, 32'h0, seen);
        spi_byte(8'h0F, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        checks++;
        if (strobe_cnt - s0 !== 0) begin
            errors++;
            $display("FAIL led_strobe_early: got %0d expected 0", strobe_cnt - s0);
        end
        spi_byte(8'h00, rx);
        checks++;
        if (strobe_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL led_strobe_pulse: got %0d expected 1", strobe_cnt - s0);
        end
        cs_end();
        checks++;
        if ({led4, led3, led2, led1} !== 4'b0000) begin
            errors++;
            $display("FAIL led_outputs: got %b expected 0000", {led4, led3, led2, led1});
        end
    endtask

    task automatic test_reads();
        check_read("read_led", 32'h0, 40'hA3_0F_00_00_00);
        check_read("read_id", 32'h18, 40'hA3_31_4B_39_54);
        check_read("read_unmapped", 32'h40, 40'hA3_00_00_00_00);
        pwm_in = 6'b101101;
        check_read("read_pwmin", 32'h4, 40'hA3_2D_00_00_00);
        // full 32-bit compare: 0x1_0000_0000-style alias must not hit LED
        check_read("read_alias", 32'h0100_0000, 40'hA3_00_00_00_00);
    endtask

    task automatic test_led_upper();
        spi_write(32'h0, 32'hFFFF_FFF5);
        check_read("led_upper_bits", 32'h0, 40'hA3_05_00_00_00);
        checks++;
        if ({led4, led3, led2, led1} !== 4'b1010) begin
            errors++;
            $display("FAIL led_pattern5: got %b expected 1010", {led4, led3, led2, led1});
        end
    endtask

    task automatic test_motor();
        int hi1, hi2;
        spi_write(32'h8, 32'h0000_0080);
        spi_write(32'hC, 32'h0000_00FF);
        hi1 = 0;
        hi2 = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            hi1 += m1;
            hi2 += m2;
        end
        checks++;
        if (hi1 != 128) begin
            errors++;
            $display("FAIL motor1_duty80: got %0d expected 128", hi1);
        end
        checks++;
        if (hi2 != 255) begin
            errors++;
            $display("FAIL motor2_dutyFF: got %0d expected 255", hi2);
        end
        check_read("read_motor2", 32'hC, 40'hA3_FF_00_00_00);
        spi_write(32'h8, 32'h0000_0000);
        hi1 = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            hi1 += m1;
        end
        checks++;
        if (hi1 != 0) begin
            errors++;
            $display("FAIL motor1_duty0: got %0d expected 0", hi1);
        end
    endtask

    task automatic test_abort_write();
        logic [7:0] rx;
        logic seen;
        int s0;
        s0 = strobe_cnt;
        cs_begin();
        send_hdr(8'hA2, 32'h0, seen);
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        cs_end();
        checks++;
        if ({led4, led3, led2, led1} !== 4'b1010 || strobe_cnt != s0) begin
            errors++;
            $display("FAIL abort_write: leds %b strobes %0d expected 1010 and 0",
                     {led4, led3, led2, led1}, strobe_cnt - s0);
        end
        check_read("abort_readback", 32'h0, 40'hA3_05_00_00_00);
    endtask

    task automatic test_bad_cmd();
        logic [7:0] rx;
        logic seen;
        logic any;
        int s0;
        s0 = strobe_cnt;
        cs_begin();
        send_hdr(8'h55, 32'h0, seen);
        any = seen;
        for (int b = 0; b < 9; b++) begin
            spi_byte(b == 0 ? 8'h0A : 8'hFF, rx);
            any = any | (|rx);
        end
        cs_end();
        checks++;
        if (any !== 1'b0) begin
            errors++;
            $display("FAIL bad_cmd_miso: got %b expected 0", any);
        end
        checks++;
        if ({led4, led3, led2, led1} !== 4'b1010 || strobe_cnt != s0) begin
            errors++;
            $display("FAIL bad_cmd_nowrite: leds %b strobes %0d expected 1010 and 0",
                     {led4, led3, led2, led1}, strobe_cnt - s0);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx;
        logic seen;
        logic any;
        cs_begin();
        send_hdr(8'hA1, 32'h0, seen);
        spi_byte(8'h00, rx);
        checks++;
        if (rx !== 8'hA3) begin
            errors++;
            $display("FAIL midread_hdr: got %h expected a3", rx);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (miso !== 1'b0) begin
            errors++;
            $display("FAIL midread_rst_miso: got %b expected 0", miso);
        end
        rst = 1'b0;
        any = 1'b0;
        for (int b = 0; b < 2; b++) begin
            spi_byte(8'hFF, rx);
            any = any | (|rx);
        end
        checks++;
        if (any !== 1'b0) begin
            errors++;
            $display("FAIL midread_idle_miso: got %b expected 0", any);
        end
        cs_end();
        checks++;
        if ({led4, led3, led2, led1} !== 4'b1111) begin
            errors++;
            $display("FAIL midread_led_reset: got %b expected 1111", {led4, led3, led2, led1});
        end
        spi_write(32'h0, 32'h0000_0009);
        check_read("post_reset_read", 32'h0, 40'hA3_09_00_00_00);
    endtask

    task automatic test_back_to_back();
        spi_write(32'h10, 32'h1234_5642);
        spi_write(32'h14, 32'h0000_0007);
        check_read("b2b_motor3", 32'h10, 40'hA3_42_00_00_00);
        check_read("b2b_motor4", 32'h14, 40'hA3_07_00_00_00);
        spi_write(32'h18, 32'h0000_0000);
        check_read("id_readonly", 32'h18, 40'hA3_31_4B_39_54);
    endtask

    initial begin
        test_reset();
        test_led_write();
        test_reads();
        test_led_upper();
        test_motor();
        test_abort_write();
        test_bad_cmd();
        test_reset_mid_read();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
